multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 112 +++++++++++
 tb/tb_multicycle_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 subset control FSM: fetch/decode/execute/memory/writeback
// sequencing with bounded memory-ack waits and a sticky trap state.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        br_taken,
  output logic [31:0] ir,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Counter only needs to reach TIMEOUT-1; the cycle after that is the trap decision.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [2:0]    state, nstate;
  logic [CW-1:0] wcnt;
  logic [6:0]    op;
  logic          is_load, is_store, is_branch, is_jal, legal, uses_imm;
  logic          expired, retire;
  logic          trap_ill, trap_imem, trap_dmem;

  assign op        = ir[6:0];
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);
  assign is_jal    = (op == OP_JAL);
  assign legal     = (op == OP_IMM) || (op == OP_REG) || is_load || is_store ||
                     is_branch || is_jal || (op == OP_LUI);
  assign uses_imm  = (op == OP_IMM) || is_load || is_store || (op == OP_LUI);

  assign expired   = (wcnt == CW'(TIMEOUT - 1));
  assign trap_ill  = (state == S_DECODE) && !legal;
  assign trap_imem = (state == S_FETCH) && !imem_ack && expired;
  assign trap_dmem = (state == S_MEM) && !dmem_ack && expired;
  assign retire    = ((state == S_EXEC) && is_branch) ||
                     ((state == S_MEM) && is_store && dmem_ack) ||
                     (state == S_WB);

  always_comb begin
    nstate = state;
    case (state)
      S_FETCH:  if (imem_ack) nstate = S_DECODE;
                else if (expired) nstate = S_TRAP;
      S_DECODE: nstate = legal ? S_EXEC : S_TRAP;
      S_EXEC:   nstate = (is_load || is_store) ? S_MEM : (is_branch ? S_FETCH : S_WB);
      S_MEM:    if (dmem_ack) nstate = is_store ? S_FETCH : S_WB;
                else if (expired) nstate = S_TRAP;
      S_WB:     nstate = S_FETCH;
      default:  nstate = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      ir         <= 32'h0000_0013;
      instret    <= '0;
      trap_cause <= 2'd0;
      wcnt       <= '0;
    end else begin
      state <= nstate;
      if ((state == S_FETCH) && imem_ack) ir <= imem_rdata;
      if (retire) instret <= instret + 32'd1;
      // Any state change restarts the count, which covers entry to FETCH and MEM.
      if (nstate != state) wcnt <= '0;
      else if ((state == S_FETCH) || (state == S_MEM)) wcnt <= wcnt + CW'(1);
      if (trap_ill)       trap_cause <= 2'd1;
      else if (trap_imem) trap_cause <= 2'd2;
      else if (trap_dmem) trap_cause <= 2'd3;
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign dmem_req    = (state == S_MEM);
  assign dmem_we     = (state == S_MEM) && is_store;
  assign alu_src_imm = ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) && uses_imm;
  assign pc_we       = retire;
  assign pc_sel      = ((state == S_EXEC) && is_branch) ? br_taken : ((state == S_WB) && is_jal);
  assign reg_we      = (state == S_WB) && (ir[11:7] != 5'd0);
  assign wb_sel      = (state == S_WB) && is_load;
  assign trap        = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction pushes its expected
// outcome, which is popped and compared when it retires or traps.
module tb_multicycle_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] ir, instret;
  logic        pc_we, pc_sel, alu_src_imm, reg_we, wb_sel, trap;
  logic [1:0]  trap_cause;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_instret = '0;

  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] mreq;
    logic [1:0] cause;
    logic       pc_sel;
    logic       reg_we;
    logic       wb_sel;
    logic       imm;
    logic       dwe;
  } exp_t;

  exp_t sb[$];

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .ir(ir), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // iw = FETCH cycles before imem_ack, dly = MEM cycles before dmem_ack
  function automatic exp_t model(input logic [31:0] instr, input logic br, input int iw, input int dly);
    exp_t e;
    logic [6:0] op = instr[6:0];
    logic ld = (op == 7'b0000011);
    logic st = (op == 7'b0100011);
    logic bq = (op == 7'b1100011);
    logic jl = (op == 7'b1101111);
    logic legal = ld || st || bq || jl || (op == 7'b0010011) || (op == 7'b0110011) || (op == 7'b0110111);
    logic uimm = ld || st || (op == 7'b0010011) || (op == 7'b0110111);
    e = '0;
    if (iw >= TO) e.cause = 2'd2;
    else if (!legal) e.cause = 2'd1;
    else if ((ld || st) && dly >= TO) e.cause = 2'd3;
    case (e.cause)
      2'd0:    e.cycles = 8'(iw + (bq ? 3 : st ? 4 + dly : ld ? 5 + dly : 4));
      2'd1:    e.cycles = 8'(iw + 3);
      2'd2:    e.cycles = 8'(TO + 1);
      default: e.cycles = 8'(iw + 4 + TO);
    endcase
    if (e.cause == 2'd0 || e.cause == 2'd3) begin
      e.imm = uimm;
      if (ld || st) begin
        e.mreq = 8'((dly >= TO) ? TO : dly + 1);
        e.dwe  = st;
      end
    end
    if (e.cause == 2'd0) begin
      e.pc_sel = bq ? br : jl;
      e.reg_we = !bq && !st && (instr[11:7] != 5'd0);
      e.wb_sel = ld;
    end
    return e;
  endfunction

  // Called at a negedge with the DUT in FETCH; returns at a negedge after retire/trap.
  task automatic exec_instr(input string name, input logic [31:0] instr, input logic br,
                            input int iw, input int dly);
    exp_t e, got;
    int cyc = 0, nreg = 0, npc = 0;
    bit done = 0;
    got = '0;
    sb.push_back(model(instr, br, iw, dly));
    while (!done) begin
      imem_ack   = imem_req && (cyc >= iw);
      imem_rdata = instr;
      br_taken   = br;
      dmem_ack   = dmem_req && (int'(got.mreq) == dly);
      #1;
      if (cyc == iw + 2) got.imm = alu_src_imm;
      if (dmem_req) begin got.mreq = got.mreq + 8'd1; got.dwe = dmem_we; end
      if (reg_we) nreg++;
      if (pc_we) begin
        npc++;
        got.pc_sel = pc_sel;
        got.wb_sel = wb_sel;
        got.reg_we = reg_we;
      end
      if (trap) got.cause = trap_cause;
      cyc++;
      done = pc_we || trap || (cyc > 40);
      @(posedge clk); @(negedge clk);
    end
    got.cycles = 8'(cyc);
    imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    e = sb.pop_front();
    if (e.cause == 2'd0) exp_instret = exp_instret + 32'd1;
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s result: got %p required %p", name, got, e);
    end
    checks++;
    if (npc !== int'(e.cause == 2'd0) || nreg !== int'(e.reg_we)) begin
      failures++;
      $display("FAIL %s strobe_count: pc_we=%0d reg_we=%0d required %0d %0d",
               name, npc, nreg, e.cause == 2'd0, e.reg_we);
    end
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL %s instret: got %h required %h", name, instret, exp_instret);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (ir !== 32'h13 || instret !== 32'd0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
      failures++;
      $display("FAIL reset_regs: ir=%h instret=%h trap=%b cause=%0d", ir, instret, trap, trap_cause);
    end
    checks++;
    if ({pc_we, reg_we, dmem_req, dmem_we, wb_sel, imem_req} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_outputs: pc_we=%b reg_we=%b dmem_req=%b dmem_we=%b wb_sel=%b imem_req=%b required 000001",
               pc_we, reg_we, dmem_req, dmem_we, wb_sel, imem_req);
    end
  endtask

  task automatic test_alu();
    exec_instr("addi_x1_5", 32'h00500093, 1'b1, 0, 0);
    exec_instr("add_x3",    32'h002081B3, 1'b1, 0, 0);
    exec_instr("lui_x1",    32'h123450B7, 1'b0, 0, 0);
    exec_instr("jal_x1",    32'h008000EF, 1'b0, 0, 0);
  endtask

  task automatic test_load();
    exec_instr("lw_nodelay", 32'h0000A283, 1'b0, 0, 0);
    exec_instr("lw_delay3",  32'h0000A283, 1'b1, 0, 3);
  endtask

  task automatic test_store();
    exec_instr("sw_nodelay", 32'h0020A023, 1'b0, 0, 0);
    exec_instr("sw_delay2",  32'h0020A023, 1'b1, 0, 2);
  endtask

  task automatic test_branch();
    exec_instr("beq_taken",     32'h00208463, 1'b1, 0, 0);
    exec_instr("beq_not_taken", 32'h00208463, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    exec_instr("b2b_addi", 32'h00500093, 1'b0, 1, 0);
    exec_instr("b2b_sw",   32'h0020A023, 1'b0, 2, 1);
    exec_instr("b2b_lw",   32'h0000A283, 1'b0, 0, 1);
  endtask

  task automatic test_wrap();
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    exp_instret = 32'hFFFF_FFFF;
    exec_instr("addi_x0_wrap", 32'h00000013, 1'b1, 0, 0);
  endtask

  task automatic test_illegal();
    exec_instr("illegal_7f", 32'h0000007F, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1; br_taken = 1'b1; imem_rdata = 32'h00500093;
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if ({trap, trap_cause, imem_req, dmem_req, dmem_we, pc_we, reg_we, pc_sel, wb_sel} !== 10'b1_01_0000000 ||
          ir !== 32'h7F || instret !== exp_instret) begin
        failures++;
        $display("FAIL trap_hold cyc %0d: trap=%b cause=%0d ir=%h instret=%h req=%b%b we=%b%b%b sel=%b%b",
                 i, trap, trap_cause, ir, instret, imem_req, dmem_req, dmem_we, pc_we, reg_we, pc_sel, wb_sel);
      end
    end
    do_reset();
    #1;
    checks++;
    if (ir !== 32'h13 || trap !== 1'b0 || trap_cause !== 2'd0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL trap_reset: ir=%h trap=%b cause=%0d imem_req=%b", ir, trap, trap_cause, imem_req);
    end
  endtask

  task automatic test_timeouts();
    exec_instr("imem_timeout", 32'h00500093, 1'b0, TO, 0);
    do_reset();
    exec_instr("imem_ack_last", 32'h00500093, 1'b0, TO - 1, 0);
    exec_instr("dmem_timeout", 32'h0000A283, 1'b0, 0, TO);
    do_reset();
    exec_instr("dmem_ack_last", 32'h0000A283, 1'b0, 0, TO - 1);
  endtask

  task automatic test_reset_mid_mem();
    imem_ack = 1'b1; imem_rdata = 32'h0000A283;
    @(posedge clk); @(negedge clk);
    imem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL midmem_reach: dmem_req=%b required 1", dmem_req);
    end
    do_reset();
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0 || ir !== 32'h13 || instret !== 32'd0) begin
      failures++;
      $display("FAIL midmem_reset: imem_req=%b dmem_req=%b ir=%h instret=%h", imem_req, dmem_req, ir, instret);
    end
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || pc_we !== 1'b0 || reg_we !== 1'b0 || instret !== 32'd0) begin
      failures++;
      $display("FAIL late_dack: imem_req=%b pc_we=%b reg_we=%b instret=%h", imem_req, pc_we, reg_we, instret);
    end
    dmem_ack = 1'b0;
    exec_instr("after_midmem", 32'h00500093, 1'b0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_wrap();
    test_illegal();
    test_timeouts();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
